// File: rtl/paddle_ctrl.sv
// Breakout-style paddle controller: frame-rate movement with step acceleration,
// wall saturation and a normal/narrow width mode.
module paddle_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int PAD_W       = 100,
  parameter int MARGIN      = 10,
  parameter int START_X     = 270,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4,
  parameter int POS_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             narrow,
  input  logic             pause,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] width,
  output logic [3:0]       speed,
  output logic             at_left,
  output logic             at_right
);

  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

  // Position math is one bit wider than pos so subtractions cannot wrap.
  localparam logic [POS_W:0]   SCREEN_X   = SCREEN_W[POS_W:0];
  localparam logic [POS_W:0]   MARGIN_X   = MARGIN[POS_W:0];
  localparam logic [POS_W:0]   PAD_X      = PAD_W[POS_W:0];
  localparam logic [POS_W:0]   PAD_HALF_X = PAD_X >> 1;
  localparam logic [POS_W-1:0] START_V    = START_X[POS_W-1:0];
  localparam logic [3:0]       STEP_MIN_V = STEP_MIN[3:0];
  localparam logic [3:0]       STEP_MAX_V = STEP_MAX[3:0];
  localparam logic [CNT_W-1:0] ACCEL_V    = ACCEL_TICKS[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  state_t           state_q, state_d, state_nx;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] width_q, width_d;
  logic [3:0]       speed_q, speed_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [POS_W:0]   width_nx, right_lim, pos_x, step_x, new_pos;
  logic [3:0]       step_cur;
  logic [4:0]       step_sum;
  logic [CNT_W-1:0] cnt_cur, cnt_inc;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    pos_d    = pos_q;
    width_d  = width_q;
    speed_d  = speed_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    state_nx = IDLE;

    width_nx  = narrow ? PAD_HALF_X : PAD_X;
    right_lim = SCREEN_X - width_nx - MARGIN_X;
    pos_x     = {1'b0, pos_q};

    unique case ({btn_left, btn_right})
      2'b10:   state_nx = MOVE_L;
      2'b01:   state_nx = MOVE_R;
      default: state_nx = IDLE;
    endcase

    // Any change of state restarts the acceleration ramp.
    step_cur = (state_nx == state_q) ? step_q : STEP_MIN_V;
    cnt_cur  = (state_nx == state_q) ? cnt_q  : '0;
    step_x   = {{(POS_W-3){1'b0}}, step_cur};
    step_sum = {1'b0, step_cur} + {1'b0, STEP_MIN_V};
    cnt_inc  = cnt_cur + CNT_W'(1);
    new_pos  = pos_x;

    if (frame_tick && !pause) begin
      state_d = state_nx;
      width_d = width_nx[POS_W-1:0];

      unique case (state_nx)
        MOVE_L:  new_pos = (pos_x < MARGIN_X + step_x) ? MARGIN_X : pos_x - step_x;
        MOVE_R:  new_pos = (pos_x + step_x > right_lim) ? right_lim : pos_x + step_x;
        default: new_pos = pos_x;
      endcase
      // A width change can pull the right limit in under a stationary paddle.
      if (new_pos > right_lim) new_pos = right_lim;
      pos_d = new_pos[POS_W-1:0];

      if (state_nx == IDLE) begin
        speed_d = '0;
        step_d  = STEP_MIN_V;
        cnt_d   = '0;
      end else begin
        speed_d = step_cur;
        if (cnt_inc == ACCEL_V) begin
          step_d = (step_sum > {1'b0, STEP_MAX_V}) ? STEP_MAX_V : step_sum[3:0];
          cnt_d  = '0;
        end else begin
          step_d = step_cur;
          cnt_d  = cnt_inc;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= START_V;
      width_q <= PAD_X[POS_W-1:0];
      speed_q <= '0;
      step_q  <= STEP_MIN_V;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      width_q <= width_d;
      speed_q <= speed_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos      = pos_q;
  assign width    = width_q;
  assign speed    = speed_q;
  assign at_left  = (pos_q == MARGIN_X[POS_W-1:0]);
  assign at_right = ({1'b0, pos_q} == SCREEN_X - {1'b0, width_q} - MARGIN_X);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: acceleration ramp, wall clamps, width
// change clamp, reversal, pause and asynchronous reset.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       narrow = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] pos, width;
  logic [3:0] speed;
  logic       at_left, at_right;

  int n_checks = 0;
  int n_errors = 0;
  int below_margin = 0;

  paddle_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .narrow(narrow), .pause(pause),
    .pos(pos), .width(width), .speed(speed), .at_left(at_left), .at_right(at_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One qualifying frame strobe; returns 1 ns after the capturing edge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  int exp_r[5] = '{272, 274, 276, 278, 282};
  int exp_s[5] = '{2, 2, 2, 2, 4};

  initial begin
    #12;
    check("rst_pos", pos, 270);
    check("rst_width", width, 100);
    check("rst_speed", speed, 0);
    check("rst_at_left", at_left, 0);
    check("rst_at_right", at_right, 0);
    @(negedge clk) reset = 1'b0;

    // Acceleration ramp to the right.
    btn_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ramp_pos%0d", i + 1), pos, exp_r[i]);
      check($sformatf("ramp_spd%0d", i + 1), speed, exp_s[i]);
    end
    for (int i = 0; i < 4; i++) tick();
    check("ramp9_pos", pos, 300);
    check("ramp9_spd", speed, 6);

    // Direct reversal restarts at the minimum step.
    btn_right = 1'b0; btn_left = 1'b1;
    tick();
    check("rev_pos", pos, 298);
    check("rev_spd", speed, 2);
    btn_right = 1'b1;
    tick();
    check("both_pos", pos, 298);
    check("both_spd", speed, 0);

    // Pause freezes everything and keeps the ramp position.
    btn_left = 1'b0;
    tick();
    check("run1_pos", pos, 300);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("pause_pos", pos, 300);
    check("pause_spd", speed, 2);
    check("pause_width", width, 100);
    pause = 1'b0;
    tick();
    check("resume_pos", pos, 302);
    tick(); tick();
    check("resume4_pos", pos, 306);
    tick();
    check("resume5_pos", pos, 310);
    check("resume5_spd", speed, 4);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("async_pos", pos, 270);
    check("async_spd", speed, 0);
    @(negedge clk) reset = 1'b0;

    // Run into the left wall.
    btn_right = 1'b0; btn_left = 1'b1;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (pos < 10) below_margin++;
    end
    check("left38_pos", pos, 14);
    check("left38_at_left", at_left, 0);
    tick();
    if (pos < 10) below_margin++;
    check("left_clamp_pos", pos, 10);
    check("left_clamp_spd", speed, 8);
    check("left_at_left", at_left, 1);
    tick();
    check("left_hold_pos", pos, 10);
    check("below_margin", below_margin, 0);

    // Narrow paddle to the right wall, then widen in place.
    btn_left = 1'b0; btn_right = 1'b1; narrow = 1'b1;
    for (int i = 0; i < 200 && !at_right; i++) tick();
    check("narrow_at_right", at_right, 1);
    check("narrow_pos", pos, 580);
    check("narrow_width", width, 50);
    btn_right = 1'b0; narrow = 1'b0;
    tick();
    check("widen_width", width, 100);
    check("widen_pos", pos, 530);
    check("widen_at_right", at_right, 1);
    check("widen_spd", speed, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640: playfield width in pixels.
REQ-002 Parameter PAD_W, default 100: paddle width in normal mode; narrow mode uses PAD_W/2.
REQ-003 Parameter MARGIN, default 10: minimum gap between paddle and each side wall.
REQ-004 Parameter START_X, default 270: reset position (left edge of paddle).
REQ-005 Parameter STEP_MIN, default 2: initial step and step increment, pixels.
REQ-006 Parameter STEP_MAX, default 8: step ceiling, pixels.
REQ-007 Parameter ACCEL_TICKS, default 4: moves at one step size before the step increases.
REQ-008 Parameter POS_W, default 10: width of position and width outputs.
REQ-009 clk  input  1  single clock; all state on rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 frame_tick  input  1  one-cycle update strobe, once per video frame.
REQ-012 btn_left  input  1  move-left request, level.
REQ-013 btn_right  input  1  move-right request, level.
REQ-014 narrow  input  1  1 = half-width paddle mode.
REQ-015 pause  input  1  1 = freeze paddle.
REQ-016 pos  output  POS_W  paddle left-edge x, registered.
REQ-017 width  output  POS_W  current paddle width, registered.
REQ-018 speed  output  4  step applied on last move; 0 when idle.
REQ-019 at_left  output  1  pos == MARGIN.
REQ-020 at_right  output  1  pos == SCREEN_W - width - MARGIN.

Function
REQ-021 All state SHALL update only on clk edges with frame_tick=1 and pause=0; otherwise all outputs hold.
REQ-022 FSM states SHALL be IDLE, MOVE_L, MOVE_R; next state per tick: left-only -> MOVE_L, right-only -> MOVE_R, none or both -> IDLE.
REQ-023 On entry to MOVE_L/MOVE_R from any other state (incl. direct reversal), step SHALL be STEP_MIN and move-counter 0; move applied the same tick.
REQ-024 While remaining in the same move state, each tick SHALL apply current step, increment move-counter; when counter reaches ACCEL_TICKS, step += STEP_MIN saturating at STEP_MAX, counter cleared.
REQ-025 Tick n (1-based) of a continuous run SHALL use step min(STEP_MIN*(1+floor((n-1)/ACCEL_TICKS)), STEP_MAX).
REQ-026 Moves SHALL saturate: pos_new = max(pos-step, MARGIN) left, min(pos+step, SCREEN_W-width_new-MARGIN) right; never skipped, never overshoot.
REQ-027 Arithmetic SHALL be done at POS_W+1 bits to avoid wrap below 0.
REQ-028 width SHALL load PAD_W or PAD_W/2 from narrow on each qualifying tick; pos SHALL be clamped against the new right limit in the same update, in any state.
REQ-029 Entering IDLE SHALL set speed=0, clear step/counter; pos held except REQ-028 clamp.
REQ-030 speed SHALL show the step applied on that tick, including a saturated (clamped) move.
REQ-031 at_left/at_right SHALL be derived from registered pos and width (combinational compare allowed).

Reset
REQ-032 reset=1 SHALL immediately force pos=START_X, width=PAD_W, speed=0, state IDLE, step=STEP_MIN, counter=0, regardless of clk.
REQ-033 First qualifying tick after reset release SHALL behave as entry from IDLE.

Verification
REQ-034 Reset, hold btn_right 5 ticks -> pos 272,274,276,278,282; speed 2,2,2,2,4.
REQ-035 Hold btn_left from reset until stable -> pos ends exactly 10, never <10, at_left=1, speed reflects clamped step.
REQ-036 narrow=1, hold right until at_right (pos=580, width=50); release, set narrow=0, one tick -> width=100, pos=530, at_right=1.
REQ-037 Right held 9 ticks (speed 6), then left only -> next tick speed=2, pos decreases by 2; both buttons -> state IDLE, speed=0, pos unchanged.
REQ-038 pause=1 with btn_right and frame_tick pulses -> pos, speed, width unchanged; pause=0 resumes with step continuity.
REQ-039 Assert reset between clk edges mid-move -> pos=270, speed=0 before next edge.
